// File: rtl/p_hit_unit.sv
`default_nettype none
// ============================================================================
// Module      : p_hit_unit
// Description : Ray/triangle-plane intersection point P = O + t*D, with
//               t = dot(N, v0-O) / dot(N, D) in signed fixed point. The result
//               and v0 are queued in a first-word-fall-through output FIFO.
//               Optional macro PHIT_SAT_EN clamps t and P instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module p_hit_unit #(
  parameter int D_BITS     = 32,
  parameter int Q_BITS     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0][D_BITS-1:0] tri_normal_in,
  input  logic [2:0][D_BITS-1:0] v0_in,
  input  logic [2:0][D_BITS-1:0] origin_in,
  input  logic [2:0][D_BITS-1:0] dir,
  input  logic                   in_wr_en,
  output logic                   in_full,
  output logic [2:0][D_BITS-1:0] p_hit,
  output logic [2:0][D_BITS-1:0] v0_out,
  input  logic                   out_rd_en,
  output logic                   out_empty
);
  localparam int c_PROD_W = 2 * D_BITS;
  localparam int c_SUM_W  = 2 * D_BITS + 2;
  localparam int c_QUO_W  = 48;
  localparam int c_DVD_W  = c_SUM_W + Q_BITS;
  localparam int c_HI_W   = c_DVD_W - c_QUO_W;
  localparam int c_T_W    = c_QUO_W + 1;
  localparam int c_PS_W   = c_PROD_W + 1;
  localparam int c_AW     = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = $clog2(c_QUO_W);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_QUO_W - 1);
  localparam logic [c_AW:0]      c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [D_BITS-1:0]  c_MAX   = {1'b0, {(D_BITS-1){1'b1}}};
  localparam logic [D_BITS-1:0]  c_MIN   = {1'b1, {(D_BITS-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_DIV, S_MUL, S_WR} state_t;
  state_t r_state, w_next;

  logic [2:0][D_BITS-1:0]  r_n, r_v0, r_o, r_d, r_p;
  logic [c_SUM_W-1:0]      r_den, r_rem;
  logic [c_QUO_W-1:0]      r_quo;
  logic                    r_neg, r_ovf;
  logic [c_CNT_W-1:0]      r_cnt;

  logic [2:0][c_SUM_W-1:0] w_pn, w_pd;
  logic [2:0][D_BITS-1:0]  w_p;
  logic [c_SUM_W-1:0]      w_num, w_den, w_num_mag, w_den_mag, w_hi;
  logic [c_DVD_W-1:0]      w_dvd;
  logic                    w_den_zero, w_ovf;
  logic [c_SUM_W:0]        w_trial, w_sub;
  logic                    w_ge;
  logic [c_QUO_W-1:0]      w_q;
  logic [c_T_W-1:0]        w_t_full;
  logic [D_BITS-1:0]       w_t;
  logic                    w_push, w_pop, w_fifo_full;

  for (genvar i = 0; i < 3; i++) begin : g_axis
    logic [D_BITS-1:0]   w_diff;
    logic [c_PROD_W-1:0] w_prod_n, w_prod_d, w_tp, w_sh;
    logic [c_PS_W-1:0]   w_sum;

    assign w_diff   = r_v0[i] - r_o[i];
    assign w_prod_n = {{D_BITS{r_n[i][D_BITS-1]}}, r_n[i]} * {{D_BITS{w_diff[D_BITS-1]}}, w_diff};
    assign w_prod_d = {{D_BITS{r_n[i][D_BITS-1]}}, r_n[i]} * {{D_BITS{r_d[i][D_BITS-1]}}, r_d[i]};
    assign w_pn[i]  = {{2{w_prod_n[c_PROD_W-1]}}, w_prod_n};
    assign w_pd[i]  = {{2{w_prod_d[c_PROD_W-1]}}, w_prod_d};

    assign w_tp  = {{D_BITS{w_t[D_BITS-1]}}, w_t} * {{D_BITS{r_d[i][D_BITS-1]}}, r_d[i]};
    assign w_sh  = $signed(w_tp) >>> Q_BITS;
    assign w_sum = {{(c_PS_W-D_BITS){r_o[i][D_BITS-1]}}, r_o[i]} + {w_sh[c_PROD_W-1], w_sh};
`ifdef PHIT_SAT_EN
    assign w_p[i] = ((&w_sum[c_PS_W-1:D_BITS-1]) || !(|w_sum[c_PS_W-1:D_BITS-1]))
                    ? w_sum[D_BITS-1:0] : (w_sum[c_PS_W-1] ? c_MIN : c_MAX);
`else
    logic w_unused_sum;
    assign w_unused_sum = ^w_sum[c_PS_W-1:D_BITS];
    assign w_p[i] = w_sum[D_BITS-1:0];
`endif
  end

  assign w_num      = w_pn[0] + w_pn[1] + w_pn[2];
  assign w_den      = w_pd[0] + w_pd[1] + w_pd[2];
  assign w_num_mag  = w_num[c_SUM_W-1] ? -w_num : w_num;
  assign w_den_mag  = w_den[c_SUM_W-1] ? -w_den : w_den;
  assign w_den_zero = (w_den == '0);
  assign w_dvd      = {w_num_mag, {Q_BITS{1'b0}}};
  // Dividend bits above the 48 quotient bits preload the remainder; if they
  // already reach the divisor the quotient cannot fit and is forced to max.
  assign w_hi       = {{(c_SUM_W-c_HI_W){1'b0}}, w_dvd[c_DVD_W-1 -: c_HI_W]};
  assign w_ovf      = (w_hi >= w_den_mag);

  assign w_trial = {r_rem, r_quo[c_QUO_W-1]};
  assign w_sub   = w_trial - {1'b0, r_den};
  assign w_ge    = (w_trial >= {1'b0, r_den});

  assign w_q      = r_ovf ? '1 : r_quo;
  assign w_t_full = r_neg ? -{1'b0, w_q} : {1'b0, w_q};
`ifdef PHIT_SAT_EN
  assign w_t = ((&w_t_full[c_T_W-1:D_BITS-1]) || !(|w_t_full[c_T_W-1:D_BITS-1]))
               ? w_t_full[D_BITS-1:0] : (w_t_full[c_T_W-1] ? c_MIN : c_MAX);
`else
  logic w_unused_t;
  assign w_unused_t = ^w_t_full[c_T_W-1:D_BITS];
  assign w_t = w_t_full[D_BITS-1:0];
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    in_full = 1'b1;
    w_push  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_full = 1'b0;
        if (in_wr_en) w_next = S_DOT;
      end
      S_DOT:  w_next = w_den_zero ? S_MUL : S_DIV;
      S_DIV:  if (r_cnt == c_LAST) w_next = S_MUL;
      S_MUL:  w_next = S_WR;
      S_WR: begin
        w_push = !w_fifo_full;
        if (!w_fifo_full) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    case (r_state)
      S_IDLE: if (in_wr_en) begin
        r_n  <= tri_normal_in;
        r_v0 <= v0_in;
        r_o  <= origin_in;
        r_d  <= dir;
      end
      S_DOT: begin
        r_den <= w_den_mag;
        r_rem <= w_hi;
        r_quo <= w_den_zero ? '0 : w_dvd[c_QUO_W-1:0];
        r_neg <= !w_den_zero && (w_num[c_SUM_W-1] ^ w_den[c_SUM_W-1]);
        r_ovf <= !w_den_zero && w_ovf;
        r_cnt <= '0;
      end
      S_DIV: begin
        r_rem <= w_ge ? w_sub[c_SUM_W-1:0] : w_trial[c_SUM_W-1:0];
        r_quo <= {r_quo[c_QUO_W-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end
      S_MUL:   r_p <= w_p;
      default: ;
    endcase
  end

  logic [2:0][D_BITS-1:0] r_mem_p [FIFO_DEPTH];
  logic [2:0][D_BITS-1:0] r_mem_v [FIFO_DEPTH];
  logic [c_AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]          r_count;

  assign out_empty   = (r_count == '0);
  assign w_fifo_full = (r_count == c_DEPTH);
  assign w_pop       = out_rd_en && !out_empty;
  assign p_hit       = out_empty ? '0 : r_mem_p[r_rd_ptr];
  assign v0_out      = out_empty ? '0 : r_mem_v[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_p[r_wr_ptr] <= r_p;
      r_mem_v[r_wr_ptr] <= r_v0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_p_hit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_p_hit_unit
// Description : Directed self-checking bench for p_hit_unit (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p_hit_unit;
  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [2:0][31:0] tri_normal_in = '0;
  logic [2:0][31:0] v0_in = '0;
  logic [2:0][31:0] origin_in = '0;
  logic [2:0][31:0] dir = '0;
  logic             in_wr_en = 1'b0;
  logic             in_full;
  logic [2:0][31:0] p_hit;
  logic [2:0][31:0] v0_out;
  logic             out_rd_en = 1'b0;
  logic             out_empty;

  int n_tests = 0;
  int n_fail  = 0;

  p_hit_unit dut (
    .clock(clock), .reset(reset),
    .tri_normal_in(tri_normal_in), .v0_in(v0_in), .origin_in(origin_in), .dir(dir),
    .in_wr_en(in_wr_en), .in_full(in_full),
    .p_hit(p_hit), .v0_out(v0_out),
    .out_rd_en(out_rd_en), .out_empty(out_empty)
  );

  always #5 clock = ~clock;

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [95:0] n, input logic [95:0] v, input logic [95:0] o, input logic [95:0] d);
    for (int i = 0; i < 200 && in_full; i++) tick();
    check("push_ready", {95'd0, in_full}, 96'd0);
    tri_normal_in = n;
    v0_in         = v;
    origin_in     = o;
    dir           = d;
    in_wr_en      = 1'b1;
    tick();
    in_wr_en = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [95:0] exp_p, input logic [95:0] exp_v);
    for (int i = 0; i < 200 && out_empty; i++) tick();
    check({tag, "_valid"}, {95'd0, out_empty}, 96'd0);
    check({tag, "_p"}, p_hit, exp_p);
    check({tag, "_v0"}, v0_out, exp_v);
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] FIVE = 32'h0005_0000;

  initial begin
    logic [95:0] nz, v5, zero3;
    nz    = v3(0, 0, ONE);
    v5    = v3(0, 0, FIVE);
    zero3 = '0;

    // Reset state
    repeat (3) tick();
    check("rst_in_full", {95'd0, in_full}, 96'd0);
    check("rst_out_empty", {95'd0, out_empty}, 96'd1);
    check("rst_p_hit", p_hit, 96'd0);
    check("rst_v0_out", v0_out, 96'd0);
    reset = 1'b1;
    tick();

    // Basic job, also checks latency window
    push(nz, v5, zero3, v3(0, 0, ONE));
    check("busy_after_accept", {95'd0, in_full}, 96'd1);
    repeat (50) tick();
    check("lat_empty_k50", {95'd0, out_empty}, 96'd1);
    repeat (2) tick();
    check("lat_valid_k52", {95'd0, out_empty}, 96'd0);
    get_result("basic", v5, v5);

    push(nz, v5, zero3, v3(ONE, 0, ONE));
    get_result("dir_x", v3(FIVE, 0, FIVE), v5);

    push(nz, v5, v3(0, 0, 32'h000A_0000), v3(0, 0, 32'hFFFF_0000));
    get_result("neg_num_den", v5, v5);

    push(nz, v5, v3(32'h1111_0000, 32'h0002_0000, 32'h0007_0000), v3(ONE, 0, 0));
    get_result("den_zero", v3(32'h1111_0000, 32'h0002_0000, 32'h0007_0000), v5);

    // t = 1/3 -> 0x5555
    push(nz, v3(0, 0, ONE), zero3, v3(0, 0, 32'h0003_0000));
    get_result("frac_t", v3(0, 0, 32'h0000_FFFF), v3(0, 0, ONE));

    // t = -0x5555; x product floors toward -inf
    push(nz, v3(0, 0, 32'hFFFF_0000), zero3, v3(32'h0001_0001, 0, 32'h0003_0000));
    get_result("neg_t_floor", v3(32'hFFFF_AAAA, 0, 32'hFFFF_0001), v3(0, 0, 32'hFFFF_0000));

    // Back-pressure: five jobs, no pops
    for (int j = 1; j <= 5; j++) push(nz, v3(0, 0, 32'(j) << 16), zero3, v3(0, 0, ONE));
    repeat (60) tick();
    check("bp_stuck_busy", {95'd0, in_full}, 96'd1);
    check("bp_head1", p_hit, v3(0, 0, 32'h0001_0000));
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    check("bp_head2_after_pop", p_hit, v3(0, 0, 32'h0002_0000));
    tick();
    check("bp_released", {95'd0, in_full}, 96'd0);
    for (int j = 2; j <= 5; j++)
      get_result($sformatf("bp_order%0d", j), v3(0, 0, 32'(j) << 16), v3(0, 0, 32'(j) << 16));
    check("bp_drained", {95'd0, out_empty}, 96'd1);

    // Reset during DIV with a stale result still queued
    push(nz, v5, zero3, v3(0, 0, ONE));
    for (int i = 0; i < 200 && out_empty; i++) tick();
    check("pre_rst_queued", {95'd0, out_empty}, 96'd0);
    push(nz, v3(0, 0, 32'h0009_0000), zero3, v3(0, 0, ONE));
    repeat (21) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_in_full", {95'd0, in_full}, 96'd0);
    check("mid_rst_out_empty", {95'd0, out_empty}, 96'd1);
    check("mid_rst_p_hit", p_hit, 96'd0);
    push(nz, v5, zero3, v3(ONE, 0, ONE));
    get_result("after_rst", v3(FIVE, 0, FIVE), v5);
    check("after_rst_empty", {95'd0, out_empty}, 96'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
